// File: rtl/serializador_entrada.sv
// Parallel-to-serial feeder for the pattern recognizer: valid/ready word intake, divided bit clock, gapless streaming.
// Optional even-parity bit after the data bits when SERIALIZADOR_PARIDAD_EN is defined.
module serializador_entrada #(
  parameter int ANCHO       = 8,
  parameter int DIVISOR     = 1,
  parameter int MSB_PRIMERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] dato,
  input  logic             dato_valido,
  output logic             listo,
  output logic             salida_serie,
  output logic             bit_paso,
  output logic             ocupado
);

  localparam int CW = $clog2(ANCHO + 2);
  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DW-1:0] DIV_FIN = DW'(DIVISOR - 1);
`ifdef SERIALIZADOR_PARIDAD_EN
  localparam int NBITS = ANCHO + 1;
`else
  localparam int NBITS = ANCHO;
`endif
  localparam logic [CW-1:0] CNT_FIN = CW'(NBITS);

  typedef enum logic {
    REPOSO   = 1'b0,
    DESPLAZA = 1'b1
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             salida_q, salida_d;
  logic             paso_q, paso_d;
  logic             ocup_q, ocup_d;
`ifdef SERIALIZADOR_PARIDAD_EN
  logic             paridad_q, paridad_d;
`endif

  logic ultimo;
  logic acepta;

  function automatic logic bit_actual(input logic [ANCHO-1:0] s);
    if (MSB_PRIMERO != 0) return s[ANCHO-1];
    else                  return s[0];
  endfunction

  function automatic logic [ANCHO-1:0] desplazar(input logic [ANCHO-1:0] s);
    if (MSB_PRIMERO != 0) return {s[ANCHO-2:0], 1'b0};
    else                  return {1'b0, s[ANCHO-1:1]};
  endfunction

  // cnt_q holds the 1-based index of the bit on the line, so the last bit sits at CNT_FIN
  assign ultimo = (estado_q == DESPLAZA) && (div_q == DIV_FIN) && (cnt_q == CNT_FIN);
  assign listo  = !rst && ((estado_q == REPOSO) || ultimo);
  assign acepta = dato_valido && listo;

  always_comb begin
    estado_d  = estado_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
`ifdef SERIALIZADOR_PARIDAD_EN
    paridad_d = paridad_q;
`endif
    if (acepta) begin
      estado_d  = DESPLAZA;
      shift_d   = dato;
      cnt_d     = CW'(1);
      div_d     = '0;
`ifdef SERIALIZADOR_PARIDAD_EN
      paridad_d = ^dato;
`endif
    end else if (estado_q == DESPLAZA) begin
      if (div_q == DIV_FIN) begin
        div_d = '0;
        if (cnt_q == CNT_FIN) begin
          estado_d  = REPOSO;
          shift_d   = '0;
          cnt_d     = '0;
`ifdef SERIALIZADOR_PARIDAD_EN
          paridad_d = 1'b0;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = desplazar(shift_q);
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    // Outputs are registered: derive them from the state about to be loaded
    ocup_d   = (estado_d == DESPLAZA);
    paso_d   = ocup_d && (div_d == '0);
    salida_d = 1'b0;
    if (ocup_d) begin
`ifdef SERIALIZADOR_PARIDAD_EN
      if (cnt_d == CW'(ANCHO + 1)) salida_d = paridad_d;
      else                         salida_d = bit_actual(shift_d);
`else
      salida_d = bit_actual(shift_d);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= REPOSO;
      shift_q   <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      salida_q  <= 1'b0;
      paso_q    <= 1'b0;
      ocup_q    <= 1'b0;
`ifdef SERIALIZADOR_PARIDAD_EN
      paridad_q <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      salida_q  <= salida_d;
      paso_q    <= paso_d;
      ocup_q    <= ocup_d;
`ifdef SERIALIZADOR_PARIDAD_EN
      paridad_q <= paridad_d;
`endif
    end
  end

  assign salida_serie = salida_q;
  assign bit_paso     = paso_q;
  assign ocupado      = ocup_q;

endmodule

// File: tb/tb_serializador_entrada.sv
// Scoreboard bench for serializador_entrada: one default instance and one with DIVISOR=3, LSB first.
module tb_serializador_entrada;

  logic       clk;
  logic       rst;
  logic [7:0] dato_a, dato_b;
  logic       valid_a, valid_b;
  logic       listo_a, listo_b;
  logic       sal_a, sal_b;
  logic       paso_a, paso_b;
  logic       ocup_a, ocup_b;

  int checks;
  int failures;

  typedef struct {
    logic sal;
    logic paso;
    logic listo;
  } exp_t;

  exp_t exp_q[$];

  serializador_entrada #(.ANCHO(8), .DIVISOR(1), .MSB_PRIMERO(1)) u_dut_a (
    .clk(clk), .rst(rst), .dato(dato_a), .dato_valido(valid_a),
    .listo(listo_a), .salida_serie(sal_a), .bit_paso(paso_a), .ocupado(ocup_a)
  );

  serializador_entrada #(.ANCHO(8), .DIVISOR(3), .MSB_PRIMERO(0)) u_dut_b (
    .clk(clk), .rst(rst), .dato(dato_b), .dato_valido(valid_b),
    .listo(listo_b), .salida_serie(sal_b), .bit_paso(paso_b), .ocupado(ocup_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle trace of one frame, built from the word alone
  task automatic push_word(input logic [7:0] w, input int div, input bit msb);
    int   nb;
    logic b;
    exp_t e;
    nb = 8;
`ifdef SERIALIZADOR_PARIDAD_EN
    nb = 9;
`endif
    for (int i = 0; i < nb; i++) begin
      if (i == 8) b = ^w;
      else        b = msb ? w[7-i] : w[i];
      for (int r = 0; r < div; r++) begin
        e.sal   = b;
        e.paso  = (r == 0);
        e.listo = (i == nb - 1) && (r == div - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; dato_a = '0; dato_b = '0;
    @(negedge clk);
    checks++;
    if (listo_a !== 1'b0 || listo_b !== 1'b0) begin
      failures++; $display("FAIL reset_listo got=%b%b exp=00", listo_a, listo_b);
    end
    @(negedge clk);
    checks++;
    if ({sal_a, paso_a, ocup_a, listo_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_outs got=%b exp=0000", {sal_a, paso_a, ocup_a, listo_a});
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({sal_a, paso_a, ocup_a, listo_a} !== 4'b0001 ||
          {sal_b, paso_b, ocup_b, listo_b} !== 4'b0001) begin
        failures++;
        $display("FAIL idle c=%0d got_a=%b got_b=%b exp=0001", c,
                 {sal_a, paso_a, ocup_a, listo_a}, {sal_b, paso_b, ocup_b, listo_b});
      end
    end
  endtask

  task automatic test_single(input logic [7:0] w, input string nombre);
    int   n;
    exp_t e;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (listo_a !== 1'b1) begin
      failures++; $display("FAIL %s listo_idle got=%b exp=1", nombre, listo_a);
    end
    dato_a = w; valid_a = 1'b1;
    push_word(w, 1, 1'b1);
    n = exp_q.size();
    @(negedge clk);
    valid_a = 1'b0; dato_a = 8'h5C;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (sal_a !== e.sal || paso_a !== e.paso || listo_a !== e.listo || ocup_a !== 1'b1) begin
        failures++;
        $display("FAIL %s c=%0d got sal/paso/listo/ocup=%b%b%b%b exp=%b%b%b1", nombre, c,
                 sal_a, paso_a, listo_a, ocup_a, e.sal, e.paso, e.listo);
      end
    end
    @(negedge clk);
    checks++;
    if ({sal_a, paso_a, ocup_a, listo_a} !== 4'b0001) begin
      failures++; $display("FAIL %s end got=%b exp=0001", nombre, {sal_a, paso_a, ocup_a, listo_a});
    end
  endtask

  task automatic test_divider;
    int   n;
    int   strobes;
    exp_t e;
    exp_q.delete();
    strobes = 0;
    @(negedge clk);
    dato_b = 8'h0D; valid_b = 1'b1;
    push_word(8'h0D, 3, 1'b0);
    n = exp_q.size();
    @(negedge clk);
    valid_b = 1'b0; dato_b = 8'hFF;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      e = exp_q.pop_front();
      if (paso_b === 1'b1) strobes++;
      checks++;
      if (sal_b !== e.sal || paso_b !== e.paso || listo_b !== e.listo || ocup_b !== 1'b1) begin
        failures++;
        $display("FAIL divider c=%0d got sal/paso/listo/ocup=%b%b%b%b exp=%b%b%b1", c,
                 sal_b, paso_b, listo_b, ocup_b, e.sal, e.paso, e.listo);
      end
    end
    checks++;
`ifdef SERIALIZADOR_PARIDAD_EN
    if (strobes != 9 || n != 27) begin
      failures++; $display("FAIL divider_len strobes=%0d cycles=%0d exp=9/27", strobes, n);
    end
`else
    if (strobes != 8 || n != 24) begin
      failures++; $display("FAIL divider_len strobes=%0d cycles=%0d exp=8/24", strobes, n);
    end
`endif
    @(negedge clk);
    checks++;
    if ({sal_b, ocup_b, listo_b} !== 3'b001) begin
      failures++; $display("FAIL divider_end got=%b exp=001", {sal_b, ocup_b, listo_b});
    end
  endtask

  task automatic test_back_to_back;
    int   n;
    exp_t e;
    exp_q.delete();
    @(negedge clk);
    dato_a = 8'hFF; valid_a = 1'b1;
    push_word(8'hFF, 1, 1'b1);
    push_word(8'h00, 1, 1'b1);
    n = exp_q.size();
    @(negedge clk);
    dato_a = 8'h00;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      if (c == n / 2 + 1) valid_a = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (sal_a !== e.sal || paso_a !== e.paso || listo_a !== e.listo || ocup_a !== 1'b1) begin
        failures++;
        $display("FAIL b2b c=%0d got sal/paso/listo/ocup=%b%b%b%b exp=%b%b%b1", c,
                 sal_a, paso_a, listo_a, ocup_a, e.sal, e.paso, e.listo);
      end
    end
    @(negedge clk);
    checks++;
    if ({sal_a, paso_a, ocup_a, listo_a} !== 4'b0001) begin
      failures++; $display("FAIL b2b_end got=%b exp=0001", {sal_a, paso_a, ocup_a, listo_a});
    end
  endtask

  task automatic test_reset_mid;
    int   n;
    exp_t e;
    exp_q.delete();
    @(negedge clk);
    dato_a = 8'hAA; valid_a = 1'b1;
    push_word(8'hAA, 1, 1'b1);
    @(negedge clk);
    valid_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (sal_a !== e.sal || ocup_a !== 1'b1) begin
        failures++; $display("FAIL midrst_pre c=%0d got=%b%b exp=%b1", c, sal_a, ocup_a, e.sal);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sal_a, ocup_a, paso_a, listo_a} !== 4'b0000) begin
      failures++; $display("FAIL midrst_hold got=%b exp=0000", {sal_a, ocup_a, paso_a, listo_a});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sal_a, ocup_a, paso_a, listo_a} !== 4'b0001) begin
      failures++; $display("FAIL midrst_release got=%b exp=0001", {sal_a, ocup_a, paso_a, listo_a});
    end
    dato_a = 8'h80; valid_a = 1'b1;
    push_word(8'h80, 1, 1'b1);
    n = exp_q.size();
    @(negedge clk);
    valid_a = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (sal_a !== e.sal || paso_a !== e.paso || listo_a !== e.listo || ocup_a !== 1'b1) begin
        failures++;
        $display("FAIL midrst_next c=%0d got sal/paso/listo/ocup=%b%b%b%b exp=%b%b%b1", c,
                 sal_a, paso_a, listo_a, ocup_a, e.sal, e.paso, e.listo);
      end
    end
    @(negedge clk);
    checks++;
    if ({sal_a, ocup_a} !== 2'b00) begin
      failures++; $display("FAIL midrst_end got=%b exp=00", {sal_a, ocup_a});
    end
  endtask

`ifdef SERIALIZADOR_PARIDAD_EN
  task automatic test_parity(input logic [7:0] w, input logic par_exp);
    int   len;
    logic ultimo_bit;
    exp_q.delete();
    len = 0;
    ultimo_bit = 1'bx;
    @(negedge clk);
    dato_a = w; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int c = 0; c < 20 && ocup_a === 1'b1; c++) begin
      if (paso_a === 1'b1) len++;
      ultimo_bit = sal_a;
      @(negedge clk);
    end
    checks++;
    if (len != 9 || ultimo_bit !== par_exp) begin
      failures++;
      $display("FAIL parity w=%h strobes=%0d par=%b exp=9/%b", w, len, ultimo_bit, par_exp);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single(8'b1011_0000, "single_b0");
    test_single(8'h0F, "single_0f");
    test_single(8'h5A, "single_5a");
    test_single(8'h01, "single_01");
    test_divider();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIALIZADOR_PARIDAD_EN
    test_parity(8'b1011_0000, 1'b1);
    test_parity(8'h0F, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
